debug_panel: RTL and testbench
==============================

DEBUG_PANEL -- requirements
Module: debug_panel

Interface
REQ-001 SHALL have parameter WIDTH, default 32: CPU/memory data and address width.
REQ-002 SHALL have parameter DIGITS, default 8: seven-segment digit count, at least 3; digits [0:DIGITS-3] show data, the top 2 show address.
REQ-003 SHALL have parameter CLKRATE, default 25_000_000: clk frequency in Hz.
REQ-004 SHALL have parameter DBMSEC, default 150: debounce window; DBMAX = CLKRATE*DBMSEC/2000 cycles.
REQ-005 SHALL have parameter VIEW_BASE, default 50_000: memory offset added to the panel address.
REQ-006 SHALL have parameter STATUS_ADDR, default 100_001: status register address.
REQ-007 SHALL have parameter SCANMSEC, default 1000: auto-scan period in ms.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 nrst  in  1  asynchronous active-low reset.
REQ-010 enw, address, wdata  in  1/WIDTH/WIDTH  CPU write enable, address, write data.
REQ-011 rdata  out  WIDTH  CPU read data, combinational.
REQ-012 button  in  4  active-low push buttons.
REQ-013 mem_enw, mem_address, mem_wdata  out  1/WIDTH/WIDTH  memory port.
REQ-014 mem_rdata  in  WIDTH  memory read data, combinational from mem_address.
REQ-015 seg  out  DIGITS x 7  active-low hex glyphs: 0=7'h40, 8=7'h00, A=7'h08, F=7'h0E.
REQ-016 view  out  1  high while the panel owns the memory port.

Function
REQ-017 Each button SHALL count while low, saturating at DBMAX+1.
- On release with count >= DBMAX: emit a one-cycle event.
- Any release: clear the count.
REQ-018 Button event actions:
- button[0]: set start flag.
- button[1]: toggle view.
- button[2]: next page.
- button[3]: panel address minus 1, saturating at 0, and page set to 0.
REQ-019 Page SHALL range 0..NPAGE-1, where NPAGE = ceil(WIDTH/(4*(DIGITS-2))).
- Next page from the last page: page becomes 0 and panel address plus 1, wrapping at 2^WIDTH.
REQ-020 When button[2] and button[3] events occur in the same cycle, button[3] SHALL win and button[2] SHALL be dropped.
REQ-021 Status register, read at STATUS_ADDR: bit0 start flag, bit1 view, bit2 autoscan enable, other bits 0; readable in both modes.
REQ-022 A CPU write to STATUS_ADDR SHALL:
- clear the start flag when wdata[0]=0;
- load the autoscan enable from wdata[2];
- never reach the memory port.
REQ-023 A start event coincident with a CPU clear SHALL leave the start flag set.
REQ-024 With view=0:
- mem_* SHALL mirror the CPU port;
- rdata SHALL be mem_rdata, except the status register.
REQ-025 With view=1:
- mem_enw=0, mem_wdata=0, mem_address=panel address+VIEW_BASE;
- CPU non-status reads return 0 and CPU writes are dropped.
REQ-026 Data digit k SHALL show nibble (page*(DIGITS-2)+k) of mem_rdata, or glyph 0 when that nibble is beyond WIDTH or view=0.
REQ-027 Address digits SHALL always show panel address bits [7:0], high nibble on seg[DIGITS-1].
REQ-028 Page and panel address SHALL be retained across view toggles.

Reset
REQ-029 nrst low SHALL asynchronously clear all of: debounce counters, start flag, view, page, panel address, autoscan enable and scan counter.
REQ-030 After reset, outputs SHALL be: view=0, mem_* mirroring the CPU port, and every seg showing glyph 0.
REQ-031 A press in progress at reset SHALL produce no event until it is released and pressed again.

Configuration
REQ-032 With PANEL_AUTOSCAN_EN defined, and view=1 with autoscan enable set, a tick every CLKRATE*SCANMSEC/1000 cycles SHALL act as a button[2] event.
- A button[2] or button[3] event SHALL restart the scan counter.
- A tick coincident with a button[2] event SHALL advance only once.
- A tick coincident with a button[3] event SHALL be dropped (button[3] wins, per REQ-020).
REQ-033 Without PANEL_AUTOSCAN_EN: no scan counter is built, status bit2 reads 0, and writes to bit2 are ignored.

Verification
REQ-034 Bench SHALL cover each scenario below:
- button[1] low for DBMAX-1 cycles then released -> view stays 0; held DBMAX cycles then released -> view=1 one cycle after release.
- View=1, panel address 0, memory[50_000]=32'h1234ABCD, DIGITS=8 -> seg[3:0] show B,A,4,3 / 3,2,1,0? no: seg[0..5] show D,C,B,A,4,3; seg[7:6] show 0,0.
- Page 1 (DIGITS=8, NPAGE=2): seg[0..1] show 2,1, the rest show 0; one button[2] event -> page 0, address 1, mem_address=50_001.
- View=1, CPU write enw=1 to 10 -> mem_enw=0; CPU read of STATUS_ADDR -> 32'h2; press button[0] -> read gives 32'h3; write 0 -> 32'h2.
- button[2] and button[3] events in the same cycle at address 5, page 1 -> address 4, page 0.
- Autoscan on, SCANMSEC scaled to 10 cycles -> page advances every 10 cycles; nrst pulse mid-count -> all state 0, no spurious advance.

Source files
------------

// File: rtl/debug_panel.sv
// debug_panel: button-driven memory viewer on seven-segment digits, sharing a CPU memory port.
// Define PANEL_AUTOSCAN_EN to build the timed auto page-advance (status bit2).
module debug_panel #(
    parameter int WIDTH       = 32,
    parameter int DIGITS      = 8,
    parameter int CLKRATE     = 25_000_000,
    parameter int DBMSEC      = 150,
    parameter int VIEW_BASE   = 50_000,
    parameter int STATUS_ADDR = 100_001,
    parameter int SCANMSEC    = 1000
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   enw,
    input  logic [WIDTH-1:0]       address,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    input  logic [3:0]             button,
    output logic                   mem_enw,
    output logic [WIDTH-1:0]       mem_address,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic [DIGITS-1:0][6:0] seg,
    output logic                   view
);
    localparam longint DBMAX = longint'(CLKRATE) * longint'(DBMSEC) / 2000;
    localparam int CW = $clog2(DBMAX + 2);
    localparam logic [CW-1:0] DB_MAX = CW'(DBMAX);
    localparam logic [CW-1:0] DB_SAT = CW'(DBMAX + 1);
    localparam int DW = DIGITS - 2;
    localparam int NIB = (WIDTH + 3) / 4;
    localparam int NPAGE = (NIB + DW - 1) / DW;
    localparam int PW = NPAGE > 1 ? $clog2(NPAGE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(NPAGE - 1);
    localparam int PADW = NPAGE * DW * 4;
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    logic [3:0][CW-1:0] r_cnt;
    logic [3:0]         r_arm;
    logic [3:0]         w_ev;
    logic               r_start;
    logic               r_view;
    logic [PW-1:0]      r_page;
    logic [WIDTH-1:0]   r_addr;
    logic               w_is_stat;
    logic               w_stat_wr;
    logic               w_scan_en;
    logic               w_tick;
    logic               w_next;
    logic [WIDTH-1:0]   w_status;
    logic [PADW-1:0]    w_pad;
    logic [7:0]         w_a8;

    // r_arm blocks a press that was already held when reset released
    always_comb begin
        for (int i = 0; i < 4; i++)
            w_ev[i] = r_arm[i] & button[i] & (r_cnt[i] >= DB_MAX);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
            r_arm <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_arm[i] <= r_arm[i] | button[i];
                r_cnt[i] <= (!button[i] && r_arm[i]) ?
                            ((r_cnt[i] == DB_SAT) ? r_cnt[i] : r_cnt[i] + 1'b1) : '0;
            end
        end
    end

    assign w_is_stat = (address == WIDTH'(STATUS_ADDR));
    assign w_stat_wr = enw & w_is_stat;
    assign w_next    = w_ev[2] | w_tick;

`ifdef PANEL_AUTOSCAN_EN
    localparam longint SCANCYC = longint'(CLKRATE) * longint'(SCANMSEC) / 1000;
    localparam int SW = SCANCYC > 1 ? $clog2(SCANCYC) : 1;
    localparam logic [SW-1:0] SC_LAST = SW'(SCANCYC - 1);
    logic          r_scan_en;
    logic [SW-1:0] r_scan;
    logic          w_active;
    assign w_active  = r_view & r_scan_en;
    assign w_tick    = w_active & (r_scan == SC_LAST);
    assign w_scan_en = r_scan_en;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_scan_en <= 1'b0;
            r_scan    <= '0;
        end else begin
            r_scan_en <= w_stat_wr ? wdata[2] : r_scan_en;
            r_scan    <= (!w_active || w_tick || w_ev[2] || w_ev[3]) ? '0 : r_scan + 1'b1;
        end
    end
`else
    assign w_tick    = 1'b0;
    assign w_scan_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_start <= 1'b0;
            r_view  <= 1'b0;
            r_page  <= '0;
            r_addr  <= '0;
        end else begin
            r_start <= w_ev[0] | (r_start & ~(w_stat_wr & ~wdata[0]));
            r_view  <= r_view ^ w_ev[1];
            if (w_ev[3]) begin
                r_page <= '0;
                r_addr <= (r_addr == '0) ? r_addr : r_addr - 1'b1;
            end else if (w_next) begin
                r_page <= (r_page == P_LAST) ? '0 : r_page + 1'b1;
                r_addr <= (r_page == P_LAST) ? r_addr + 1'b1 : r_addr;
            end
        end
    end

    assign view        = r_view;
    assign w_status    = WIDTH'({w_scan_en, r_view, r_start});
    assign mem_enw     = ~r_view & enw & ~w_is_stat;
    assign mem_address = r_view ? r_addr + WIDTH'(VIEW_BASE) : address;
    assign mem_wdata   = r_view ? '0 : wdata;
    assign rdata       = w_is_stat ? w_status : (r_view ? '0 : mem_rdata);
    assign w_pad       = PADW'(mem_rdata);
    assign w_a8        = 8'(r_addr);

    always_comb begin
        int n;
        n = 0;
        for (int k = 0; k < DW; k++) begin
            n = int'(r_page) * DW + k;
            seg[k] = (r_view && n < NIB) ? GLYPH[w_pad[n*4 +: 4]] : GLYPH[0];
        end
        seg[DIGITS-2] = GLYPH[w_a8[3:0]];
        seg[DIGITS-1] = GLYPH[w_a8[7:4]];
    end
endmodule

// File: tb/tb_debug_panel.sv
// tb_debug_panel: vector table for the CPU/memory mux plus directed button sequences.
module tb_debug_panel;
    localparam int DBMAX = 5;
    localparam logic [31:0] STAT = 32'd100_001;
    localparam logic [55:0] SEG_ZERO = {8{7'h40}};
    localparam logic [55:0] SEG_P0 = {7'h40, 7'h40, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [55:0] SEG_P1 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24};

    logic clk = 1'b0;
    logic nrst, enw;
    logic [31:0] address, wdata, rdata, mem_address, mem_wdata, mem_rdata;
    logic [3:0] button;
    logic mem_enw, view;
    logic [7:0][6:0] seg;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic        enw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_enw;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[5];

    debug_panel #(
        .WIDTH(32), .DIGITS(8), .CLKRATE(2000), .DBMSEC(5),
        .VIEW_BASE(50_000), .STATUS_ADDR(100_001), .SCANMSEC(5)
    ) dut (
        .clk(clk), .nrst(nrst), .enw(enw), .address(address), .wdata(wdata),
        .rdata(rdata), .button(button), .mem_enw(mem_enw), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .seg(seg), .view(view)
    );

    always #5 clk = ~clk;

    // memory model: one known word at the view base, everything else is the inverted address
    assign mem_rdata = (mem_address == 32'd50_000) ? 32'h1234ABCD : ~mem_address;

    function automatic logic [6:0] g(input logic [3:0] h);
        case (h)
            4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
            4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
            4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
            4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] exp_seg(input logic [31:0] d, input int pg, input logic [7:0] a);
        logic [55:0] s;
        int n;
        s = '0;
        for (int k = 0; k < 6; k++) begin
            n = pg * 6 + k;
            s[k*7 +: 7] = (n < 8) ? g(d[n*4 +: 4]) : 7'h40;
        end
        s[42 +: 7] = g(a[3:0]);
        s[49 +: 7] = g(a[7:4]);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] mask, input int n);
        @(negedge clk);
        button = button & ~mask;
        repeat (n) @(negedge clk);
        button = 4'hF;
    endtask

    task automatic press(input logic [3:0] mask, input int n);
        hold(mask, n);
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        enw = 1'b1;
        address = a;
        wdata = d;
        @(negedge clk);
        enw = 1'b0;
        wdata = '0;
    endtask

    task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(nm, {32'b0, rdata}, {32'b0, exp});
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd7, 32'd0, 1'b0, 32'd7, 32'd0, 32'hFFFF_FFF8};
        vecs[1] = '{1'b1, 32'd10, 32'hDEAD_BEEF, 1'b1, 32'd10, 32'hDEAD_BEEF, 32'hFFFF_FFF5};
        vecs[2] = '{1'b0, 32'd50_000, 32'd0, 1'b0, 32'd50_000, 32'd0, 32'h1234_ABCD};
        vecs[3] = '{1'b0, STAT, 32'd0, 1'b0, STAT, 32'd0, 32'd0};
        vecs[4] = '{1'b1, STAT, 32'd1, 1'b0, STAT, 32'd1, 32'd0};

        nrst = 1'b0; enw = 1'b0; address = 32'd7; wdata = '0; button = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_view", {63'b0, view}, 64'd0);
        chk("reset_seg", {8'b0, seg}, {8'b0, SEG_ZERO});
        chk("reset_mirror", {32'b0, mem_address}, 64'd7);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            enw = vecs[i].enw; address = vecs[i].addr; wdata = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_mem_enw", i), {63'b0, mem_enw}, {63'b0, vecs[i].exp_enw});
            chk($sformatf("v%0d_mem_addr", i), {32'b0, mem_address}, {32'b0, vecs[i].exp_maddr});
            chk($sformatf("v%0d_mem_wdata", i), {32'b0, mem_wdata}, {32'b0, vecs[i].exp_mwdata});
            chk($sformatf("v%0d_rdata", i), {32'b0, rdata}, {32'b0, vecs[i].exp_rdata});
        end
        @(negedge clk);
        enw = 1'b0; address = '0; wdata = '0;

        press(4'b0010, DBMAX - 1);
        chk("short_press_view", {63'b0, view}, 64'd0);
        hold(4'b0010, DBMAX);
        #1;
        chk("view_before_edge", {63'b0, view}, 64'd0);
        @(posedge clk);
        #1;
        chk("view_after_release", {63'b0, view}, 64'd1);

        enw = 1'b1; address = 32'd10; wdata = 32'h55;
        #1;
        chk("view_mem_enw", {63'b0, mem_enw}, 64'd0);
        chk("view_mem_wdata", {32'b0, mem_wdata}, 64'd0);
        chk("view_mem_addr", {32'b0, mem_address}, 64'd50_000);
        chk("view_rdata", {32'b0, rdata}, 64'd0);
        chk("view_seg_p0", {8'b0, seg}, {8'b0, SEG_P0});
        @(negedge clk);
        enw = 1'b0;

        read_chk("status_view", STAT, 32'h2);
        press(4'b0001, DBMAX);
        read_chk("status_start", STAT, 32'h3);
        cpu_write(STAT, 32'h0);
        read_chk("status_clear", STAT, 32'h2);

        press(4'b0100, DBMAX);
        chk("page1_seg", {8'b0, seg}, {8'b0, SEG_P1});
        press(4'b0100, DBMAX);
        chk("wrap_mem_addr", {32'b0, mem_address}, 64'd50_001);
        chk("wrap_addr_digits", {50'b0, seg[7], seg[6]}, {50'b0, 7'h40, 7'h79});

        press(4'b1000, DBMAX);
        chk("dec_addr", {32'b0, mem_address}, 64'd50_000);
        chk("dec_seg_p0", {8'b0, seg}, {8'b0, SEG_P0});
        press(4'b1000, DBMAX);
        chk("dec_saturate", {32'b0, mem_address}, 64'd50_000);

        for (int i = 0; i < 11; i++) press(4'b0100, DBMAX);
        chk("addr5_mem_addr", {32'b0, mem_address}, 64'd50_005);
        chk("addr5_p1_seg", {8'b0, seg}, {8'b0, exp_seg(~32'd50_005, 1, 8'd5)});
        press(4'b1100, DBMAX);
        chk("both_mem_addr", {32'b0, mem_address}, 64'd50_004);
        chk("both_p0_seg", {8'b0, seg}, {8'b0, exp_seg(~32'd50_004, 0, 8'd4)});

        address = 32'd33;
        press(4'b0010, 4 * DBMAX);
        chk("long_press_view_off", {63'b0, view}, 64'd0);
        chk("view_off_mirror", {32'b0, mem_address}, 64'd33);
        press(4'b0010, DBMAX);
        chk("retain_mem_addr", {32'b0, mem_address}, 64'd50_004);
        chk("retain_seg", {8'b0, seg}, {8'b0, exp_seg(~32'd50_004, 0, 8'd4)});

`ifdef PANEL_AUTOSCAN_EN
        for (int i = 0; i < 4; i++) press(4'b1000, DBMAX);
        cpu_write(STAT, 32'h4);
        repeat (9) @(posedge clk);
        #1;
        chk("scan_before_tick", {8'b0, seg}, {8'b0, SEG_P0});
        @(posedge clk);
        #1;
        chk("scan_tick1", {8'b0, seg}, {8'b0, SEG_P1});
        repeat (10) @(posedge clk);
        #1;
        chk("scan_tick2_addr", {32'b0, mem_address}, 64'd50_001);
        read_chk("status_scan", STAT, 32'h6);
        repeat (5) @(posedge clk);
`else
        cpu_write(STAT, 32'h5);
        read_chk("status_no_scan", STAT, 32'h2);
`endif
        #2 nrst = 1'b0;
        #1;
        chk("rst_view", {63'b0, view}, 64'd0);
        chk("rst_seg", {8'b0, seg}, {8'b0, SEG_ZERO});
        read_chk("rst_status", STAT, 32'h0);
        chk("rst_mirror", {32'b0, mem_address}, {32'b0, STAT});
        #2 nrst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("post_rst_seg", {8'b0, seg}, {8'b0, SEG_ZERO});
        press(4'b0010, DBMAX);
        chk("post_rst_mem_addr", {32'b0, mem_address}, 64'd50_000);
        chk("post_rst_seg_p0", {8'b0, seg}, {8'b0, SEG_P0});
        repeat (15) @(posedge clk);
        #1;
        chk("no_spurious_advance", {8'b0, seg}, {8'b0, SEG_P0});

        @(negedge clk);
        button = 4'b1101;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        button = 4'hF;
        @(posedge clk);
        #1;
        chk("held_through_reset", {63'b0, view}, 64'd0);
        press(4'b0010, DBMAX);
        chk("repress_after_reset", {63'b0, view}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
